// File: rtl/test_result_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_monitor_pkg
// Description : Shared types and constants for the 6502 test result monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package test_monitor_pkg;

  // Monitor sequencing: idle, window open, one-cycle evaluation, verdict held
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Failure cause reported alongside the failing channel index
  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_MISSING  = 2'd2
  } fail_code_t;

  localparam int MODE_LAST  = 0;
  localparam int MODE_FIRST = 1;

endpackage
`default_nettype wire

// File: rtl/test_result_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : test_result_monitor_if
// Description : Control, bus-snoop, check-table and verdict signals of the
//               test result monitor. master = stimulus side, slave = monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface test_result_monitor_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 200
) ();
  import test_monitor_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic                             start;
  logic                             halt;
  logic [ADDR_WIDTH-1:0]            bus_addr;
  logic [DATA_WIDTH-1:0]            bus_data;
  logic                             bus_we;
  logic [NUM_CHECKS-1:0]            chk_en;
  logic [NUM_CHECKS*ADDR_WIDTH-1:0] chk_addr;
  logic [NUM_CHECKS*DATA_WIDTH-1:0] chk_data;

  logic                             busy;
  logic                             done;
  logic                             pass;
  logic                             fail;
  logic [IW-1:0]                    fail_idx;
  fail_code_t                       fail_code;
  logic [CW-1:0]                    cycle_count;
  logic [DATA_WIDTH-1:0]            fail_data;

  modport master (
    output start, halt, bus_addr, bus_data, bus_we, chk_en, chk_addr, chk_data,
    input  busy, done, pass, fail, fail_idx, fail_code, cycle_count, fail_data
  );

  modport slave (
    input  start, halt, bus_addr, bus_data, bus_we, chk_en, chk_addr, chk_data,
    output busy, done, pass, fail, fail_idx, fail_code, cycle_count, fail_data
  );

endinterface
`default_nettype wire

// File: rtl/test_result_monitor_slot.sv
`default_nettype none
// ============================================================================
// Module      : check_slot
// Description : One check channel: address match on the write bus and the
//               seen/captured registers for that channel.
// Revision    : 1.0 - initial release
// ============================================================================
module check_slot
  import test_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  capture_en,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_data,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] expected,
  output logic                  match_now,
  output logic                  mismatch_now,
  output logic                  seen,
  output logic [DATA_WIDTH-1:0] captured
);

  logic                  r_seen;
  logic [DATA_WIDTH-1:0] r_captured;
  logic                  w_take;

  assign match_now    = capture_en && bus_we && en && (bus_addr == addr);
  // In first-write mode only the first hit is taken; later hits are ignored
  assign w_take       = match_now && ((MODE == MODE_LAST) || !r_seen);
  assign mismatch_now = w_take && (bus_data != expected);
  assign seen         = r_seen;
  assign captured     = r_captured;

  // Record that the channel was written and keep the value of interest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen     <= 1'b0;
      r_captured <= '0;
    end else if (clear) begin
      r_seen     <= 1'b0;
      r_captured <= '0;
    end else if (w_take) begin
      r_seen     <= 1'b1;
      r_captured <= bus_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : test_result_monitor
// Description : Snoops the memory write bus over a bounded window and checks
//               NUM_CHECKS address/expected pairs; reports pass/fail verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module test_result_monitor
  import test_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MODE           = 0
) (
  input  logic                  ph2,
  input  logic                  reset_b,
  test_result_monitor_if.slave  mon
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_next;
  logic                  w_start_acc, w_running, w_end;
  logic [NUM_CHECKS-1:0] w_match, w_mismatch, w_seen;
  logic [DATA_WIDTH-1:0] w_cap [NUM_CHECKS];

  logic                  w_early_any;
  logic [IW-1:0]         w_early_idx;
  logic                  w_chk_any;
  logic [IW-1:0]         w_chk_idx;
  fail_code_t            w_chk_code;
  logic [DATA_WIDTH-1:0] w_chk_data;

  logic                  r_done, r_pass, r_fail;
  logic [IW-1:0]         r_fail_idx;
  fail_code_t            r_fail_code;
  logic [CW-1:0]         r_cycle_count;
  logic [DATA_WIDTH-1:0] r_fail_data;

  assign w_start_acc = mon.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_running   = (r_state == RUN);
  assign w_end       = w_running && (mon.halt || (r_cycle_count == c_last));

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_slot
    check_slot #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .MODE       (MODE)
    ) u_slot (
      .clk          (ph2),
      .rst_n        (reset_b),
      .clear        (w_start_acc),
      .capture_en   (w_running),
      .bus_we       (mon.bus_we),
      .bus_addr     (mon.bus_addr),
      .bus_data     (mon.bus_data),
      .en           (mon.chk_en[gi]),
      .addr         (mon.chk_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      .expected     (mon.chk_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .match_now    (w_match[gi]),
      .mismatch_now (w_mismatch[gi]),
      .seen         (w_seen[gi]),
      .captured     (w_cap[gi])
    );
  end

  // Lowest-index first-write mismatch this cycle (first-write mode only)
  always_comb begin
    w_early_any = 1'b0;
    w_early_idx = '0;
    if (MODE == MODE_FIRST) begin
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
        if (w_match[i] && w_mismatch[i]) begin
          w_early_any = 1'b1;
          w_early_idx = IW'(i);
        end
      end
    end
  end

  // End-of-window evaluation: lowest-index enabled channel that fails
  always_comb begin
    w_chk_any  = 1'b0;
    w_chk_idx  = '0;
    w_chk_code = FC_NONE;
    w_chk_data = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (mon.chk_en[i] &&
          (!w_seen[i] || (w_cap[i] != mon.chk_data[i*DATA_WIDTH +: DATA_WIDTH]))) begin
        w_chk_any  = 1'b1;
        w_chk_idx  = IW'(i);
        w_chk_code = w_seen[i] ? FC_MISMATCH : FC_MISSING;
        w_chk_data = w_seen[i] ? w_cap[i] : '0;
      end
    end
  end

  // State register
  always_ff @(posedge ph2 or negedge reset_b) begin
    if (!reset_b) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; an early first-write mismatch skips CHECK
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (mon.start) w_next = RUN;
      RUN:     if (w_early_any) w_next = DONE;
               else if (w_end)  w_next = CHECK;
      CHECK:   w_next = DONE;
      DONE:    if (mon.start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  // Cycle counter and registered verdict
  always_ff @(posedge ph2 or negedge reset_b) begin
    if (!reset_b) begin
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_idx    <= '0;
      r_fail_code   <= FC_NONE;
      r_cycle_count <= '0;
      r_fail_data   <= '0;
    end else if (w_start_acc) begin
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_idx    <= '0;
      r_fail_code   <= FC_NONE;
      r_cycle_count <= '0;
      r_fail_data   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_early_any) begin
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_idx  <= w_early_idx;
            r_fail_code <= FC_MISMATCH;
            r_fail_data <= mon.bus_data;
          end else if (!w_end) begin
            r_cycle_count <= r_cycle_count + 1'b1;
          end
        end
        CHECK: begin
          r_done      <= 1'b1;
          r_pass      <= !w_chk_any;
          r_fail      <= w_chk_any;
          r_fail_idx  <= w_chk_idx;
          r_fail_code <= w_chk_code;
          r_fail_data <= w_chk_data;
        end
        default: ;
      endcase
    end
  end

  assign mon.busy        = (r_state == RUN) || (r_state == CHECK);
  assign mon.done        = r_done;
  assign mon.pass        = r_pass;
  assign mon.fail        = r_fail;
  assign mon.fail_idx    = r_fail_idx;
  assign mon.fail_code   = r_fail_code;
  assign mon.cycle_count = r_cycle_count;
  assign mon.fail_data   = r_fail_data;

endmodule
`default_nettype wire

// File: tb/tb_test_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_result_monitor
// Description : Scoreboard bench for test_result_monitor, one DUT per mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_result_monitor;
  import test_monitor_pkg::*;

  typedef struct packed {
    logic       pass;
    logic       fail;
    logic [1:0] idx;
    logic [1:0] code;
    logic [7:0] data;
    logic [7:0] cnt;
  } verdict_t;

  logic        ph2;
  logic        reset_b;
  logic        start0, start1, halt, bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic [3:0]  chk_en;
  logic [63:0] chk_addr;
  logic [31:0] chk_data;

  int vectors;
  int miscompares;
  verdict_t sb_q[$];

  test_result_monitor_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_CHECKS(4), .TIMEOUT_CYCLES(200)) bus0 ();
  test_result_monitor_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_CHECKS(4), .TIMEOUT_CYCLES(200)) bus1 ();

  assign bus0.start = start0;   assign bus1.start = start1;
  assign bus0.halt = halt;      assign bus1.halt = halt;
  assign bus0.bus_we = bus_we;  assign bus1.bus_we = bus_we;
  assign bus0.bus_addr = bus_addr; assign bus1.bus_addr = bus_addr;
  assign bus0.bus_data = bus_data; assign bus1.bus_data = bus_data;
  assign bus0.chk_en = chk_en;  assign bus1.chk_en = chk_en;
  assign bus0.chk_addr = chk_addr; assign bus1.chk_addr = chk_addr;
  assign bus0.chk_data = chk_data; assign bus1.chk_data = chk_data;

  test_result_monitor #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_CHECKS(4), .TIMEOUT_CYCLES(200), .MODE(0))
    u_dut_last (.ph2(ph2), .reset_b(reset_b), .mon(bus0));
  test_result_monitor #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_CHECKS(4), .TIMEOUT_CYCLES(200), .MODE(1))
    u_dut_first (.ph2(ph2), .reset_b(reset_b), .mon(bus1));

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  function automatic verdict_t get_v(input int sel);
    verdict_t v;
    if (sel == 0) begin
      v.pass = bus0.pass; v.fail = bus0.fail; v.idx = bus0.fail_idx;
      v.code = bus0.fail_code; v.data = bus0.fail_data; v.cnt = bus0.cycle_count;
    end else begin
      v.pass = bus1.pass; v.fail = bus1.fail; v.idx = bus1.fail_idx;
      v.code = bus1.fail_code; v.data = bus1.fail_data; v.cnt = bus1.cycle_count;
    end
    return v;
  endfunction

  // {busy, done, verdict} of one DUT
  function automatic logic [23:0] get_all(input int sel);
    if (sel == 0) return {bus0.busy, bus0.done, get_v(0)};
    else          return {bus1.busy, bus1.done, get_v(1)};
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus0.done : bus1.done;
  endfunction

  task automatic tick();
    @(posedge ph2);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic start_dut(input int sel);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic write_cyc(input logic [15:0] a, input logic [7:0] d);
    bus_we = 1'b1; bus_addr = a; bus_data = d;
    tick();
    bus_we = 1'b0; bus_addr = '0; bus_data = '0;
  endtask

  task automatic halt_cyc();
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] en, input logic [63:0] a, input logic [31:0] d);
    chk_en = en; chk_addr = a; chk_data = d;
  endtask

  task automatic wait_done(input int sel, input int budget, output int cyc);
    cyc = 0;
    while (!get_done(sel) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!get_done(sel)) begin
      vectors++; miscompares++;
      $display("FAIL wait_done dut%0d: done=0 after %0d cycles, required done=1", sel, cyc);
    end
  endtask

  task automatic test_reset();
    logic [23:0] got;
    reset_b = 1'b0;
    start0 = 0; start1 = 0; halt = 0; bus_we = 0; bus_addr = 0; bus_data = 0;
    cfg(4'h0, 64'h0, 32'h0);
    tick_n(3);
    for (int s = 0; s < 2; s++) begin
      got = get_all(s);
      vectors++;
      if (got !== 24'h0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: got %h required 000000", s, got);
      end
    end
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_last_write_timeout();
    verdict_t got, e;
    logic [23:0] all;
    int w;
    cfg(4'b0001, {48'h0, 16'h0030}, {24'h0, 8'hCE});
    sb_q.push_back('{pass:1'b1, fail:1'b0, idx:2'd0, code:2'd0, data:8'h00, cnt:8'd199});
    start_dut(0);
    tick_n(5);
    all = get_all(0);
    vectors++;
    if (all[23:22] !== 2'b10) begin
      miscompares++;
      $display("FAIL run_busy: busy/done got %b required 10", all[23:22]);
    end
    write_cyc(16'h0030, 8'h00);
    tick_n(2);
    write_cyc(16'h0030, 8'hCE);
    wait_done(0, 400, w);
    vectors++;
    if (9 + w !== 201) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles required 201", 9 + w);
    end
    e = sb_q.pop_front(); got = get_v(0);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL timeout_verdict: got %h required %h", got, e);
    end
  endtask

  task automatic test_missing();
    verdict_t got, e;
    int w;
    cfg(4'b0101, {16'h0, 16'h0031, 16'h0, 16'h0030}, {8'h0, 8'h55, 8'h0, 8'hCE});
    sb_q.push_back('{pass:1'b0, fail:1'b1, idx:2'd2, code:2'd2, data:8'h00, cnt:8'd50});
    start_dut(0);
    tick_n(4);
    write_cyc(16'h0030, 8'hCE);
    tick_n(45);
    halt_cyc();
    wait_done(0, 10, w);
    e = sb_q.pop_front(); got = get_v(0);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL missing_verdict: got %h required %h", got, e);
    end
  endtask

  task automatic test_first_write_early();
    verdict_t got, e;
    logic d;
    cfg(4'b0010, {16'h0, 16'h0, 16'h0040, 16'h0}, {8'h0, 8'h0, 8'h12, 8'h0});
    sb_q.push_back('{pass:1'b0, fail:1'b1, idx:2'd1, code:2'd1, data:8'h13, cnt:8'd10});
    start_dut(1);
    tick_n(10);
    write_cyc(16'h0040, 8'h13);
    d = get_done(1);
    vectors++;
    if (d !== 1'b1) begin
      miscompares++;
      $display("FAIL early_latency: done got %b required 1", d);
    end
    write_cyc(16'h0040, 8'h12);
    halt_cyc();
    tick_n(2);
    e = sb_q.pop_front(); got = get_v(1);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL early_verdict: got %h required %h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    verdict_t got, e;
    logic [23:0] all;
    int w;
    sb_q.push_back('{pass:1'b1, fail:1'b0, idx:2'd0, code:2'd0, data:8'h00, cnt:8'd7});
    start_dut(1);
    all = get_all(1);
    vectors++;
    if (all !== 24'h800000) begin
      miscompares++;
      $display("FAIL restart_clear: got %h required 800000", all);
    end
    tick_n(3);
    write_cyc(16'h0040, 8'h12);
    tick_n(2);
    write_cyc(16'h0040, 8'h99);
    halt_cyc();
    wait_done(1, 10, w);
    e = sb_q.pop_front(); got = get_v(1);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL b2b_verdict: got %h required %h", got, e);
    end
  endtask

  task automatic test_shared_address();
    verdict_t got, e;
    int w;
    for (int pass_run = 0; pass_run < 2; pass_run++) begin
      cfg(4'b1001, {16'h0030, 16'h0, 16'h0, 16'h0030},
          {(pass_run == 0) ? 8'hCF : 8'hCE, 8'h0, 8'h0, 8'hCE});
      if (pass_run == 0)
        sb_q.push_back('{pass:1'b0, fail:1'b1, idx:2'd3, code:2'd1, data:8'hCE, cnt:8'd6});
      else
        sb_q.push_back('{pass:1'b1, fail:1'b0, idx:2'd0, code:2'd0, data:8'h00, cnt:8'd6});
      start_dut(0);
      tick_n(3);
      write_cyc(16'h0030, 8'hCE);
      tick_n(2);
      halt_cyc();
      wait_done(0, 10, w);
      e = sb_q.pop_front(); got = get_v(0);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL shared_addr_run%0d: got %h required %h", pass_run, got, e);
      end
    end
  endtask

  task automatic test_halt_write_and_restart_ignored();
    verdict_t got, e;
    int w;
    cfg(4'b0001, {48'h0, 16'h0030}, {24'h0, 8'hA5});
    sb_q.push_back('{pass:1'b1, fail:1'b0, idx:2'd0, code:2'd0, data:8'h00, cnt:8'd40});
    start_dut(0);
    tick_n(10);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick_n(29);
    bus_we = 1'b1; bus_addr = 16'h0030; bus_data = 8'hA5; halt = 1'b1;
    tick();
    bus_we = 1'b0; bus_addr = '0; bus_data = '0; halt = 1'b0;
    wait_done(0, 10, w);
    e = sb_q.pop_front(); got = get_v(0);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL halt_write_verdict: got %h required %h", got, e);
    end
  endtask

  task automatic test_reset_mid_run();
    verdict_t got, e;
    logic [23:0] all;
    int w;
    cfg(4'b1111, {16'h0033, 16'h0032, 16'h0031, 16'h0030}, 32'h11223344);
    start_dut(0);
    tick_n(30);
    reset_b = 1'b0;
    #1;
    all = get_all(0);
    vectors++;
    if (all !== 24'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h required 000000", all);
    end
    tick_n(2);
    reset_b = 1'b1;
    tick_n(3);
    all = get_all(0);
    vectors++;
    if (all[23:22] !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy/done got %b required 00", all[23:22]);
    end
    cfg(4'b0000, 64'h0, 32'h0);
    sb_q.push_back('{pass:1'b1, fail:1'b0, idx:2'd0, code:2'd0, data:8'h00, cnt:8'd5});
    start_dut(0);
    tick_n(5);
    halt_cyc();
    wait_done(0, 10, w);
    e = sb_q.pop_front(); got = get_v(0);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL no_checks_verdict: got %h required %h", got, e);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_last_write_timeout();
    test_missing();
    test_first_write_early();
    test_back_to_back();
    test_shared_address();
    test_halt_write_and_restart_ignored();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000ns, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
